// File: rtl/seq_diferenca.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : seq_diferenca                                                  |
// | Purpose  : Windowed two-stream difference detector with per-window summary |
// |            (mismatch count, first mismatch index). Optional DIFERENCA_MASK_EN |
// |            builds the per-bit diff_mask register; otherwise it reads zero. |
// | Revision : 1.0 - initial release                                          |
// +---------------------------------------------------------------------------+
module seq_diferenca #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic [1:0]       mode,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ack,
    output logic             busy,
    output logic             done,
    output logic             diff_valid,
    output logic             diff,
    output logic [WIDTH-1:0] diff_mask,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [CNT_W-1:0] first_idx,
    output logic             first_valid
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_len;
    logic [1:0]       r_mode;
    logic [CNT_W-1:0] r_idx;
    logic             r_busy;
    logic             r_done;
    logic             r_diff_valid;
    logic             r_diff;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_first_idx;
    logic             r_first_valid;

    logic             w_diff;
    logic             w_last;
    logic             w_accept;

    // Mode 3 falls back to plain inequality.
    always_comb begin
        w_diff = (a != b);
        case (r_mode)
            2'd1:    w_diff = (a > b);
            2'd2:    w_diff = (a < b);
            default: w_diff = (a != b);
        endcase
    end

    assign w_last   = (r_idx == (r_len - CNT_W'(1)));
    assign w_accept = (r_state == S_RUN) && in_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_len         <= '0;
            r_mode        <= 2'd0;
            r_idx         <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_diff_valid  <= 1'b0;
            r_diff        <= 1'b0;
            r_cnt         <= '0;
            r_first_idx   <= '0;
            r_first_valid <= 1'b0;
        end else begin
            r_diff_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_len         <= len;
                        r_mode        <= mode;
                        r_idx         <= '0;
                        r_cnt         <= '0;
                        r_first_idx   <= '0;
                        r_first_valid <= 1'b0;
                        if (len != '0) begin
                            r_state <= S_RUN;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (in_valid) begin
                        r_diff_valid <= 1'b1;
                        r_diff       <= w_diff;
                        r_idx        <= r_idx + CNT_W'(1);
                        if (w_diff) begin
                            if (r_cnt != {CNT_W{1'b1}}) begin
                                r_cnt <= r_cnt + CNT_W'(1);
                            end
                            if (!r_first_valid) begin
                                r_first_idx   <= r_idx;
                                r_first_valid <= 1'b1;
                            end
                        end
                        if (w_last) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (ack) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

`ifdef DIFERENCA_MASK_EN
    logic [WIDTH-1:0] r_mask;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mask <= '0;
        end else if (w_accept) begin
            r_mask <= a ^ b;
        end
    end

    assign diff_mask = r_mask;
`else
    assign diff_mask = '0;
`endif

    assign busy         = r_busy;
    assign done         = r_done;
    assign diff_valid   = r_diff_valid;
    assign diff         = r_diff;
    assign mismatch_cnt = r_cnt;
    assign first_idx    = r_first_idx;
    assign first_valid  = r_first_valid;

endmodule
`default_nettype wire

// File: tb/tb_seq_diferenca.sv
`default_nettype none
// Directed self-checking bench for seq_diferenca (main instance CNT_W=8,
// second instance CNT_W=2 sharing the same stimulus for the narrow-counter case).
module tb_seq_diferenca;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] len;
    logic [1:0] mode;
    logic       in_valid;
    logic [3:0] a;
    logic [3:0] b;
    logic       ack;

    logic       busy, done, diff_valid, diff, first_valid;
    logic [3:0] diff_mask;
    logic [7:0] mismatch_cnt, first_idx;

    logic       busy2, done2, diff_valid2, diff2, first_valid2;
    logic [3:0] diff_mask2;
    logic [1:0] mismatch_cnt2, first_idx2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_diferenca #(.WIDTH(4), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .mode(mode),
        .in_valid(in_valid), .a(a), .b(b), .ack(ack),
        .busy(busy), .done(done), .diff_valid(diff_valid), .diff(diff),
        .diff_mask(diff_mask), .mismatch_cnt(mismatch_cnt),
        .first_idx(first_idx), .first_valid(first_valid)
    );

    seq_diferenca #(.WIDTH(4), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len[1:0]), .mode(mode),
        .in_valid(in_valid), .a(a), .b(b), .ack(ack),
        .busy(busy2), .done(done2), .diff_valid(diff_valid2), .diff(diff2),
        .diff_mask(diff_mask2), .mismatch_cnt(mismatch_cnt2),
        .first_idx(first_idx2), .first_valid(first_valid2)
    );

    function automatic logic [3:0] exp_mask(input logic [3:0] x);
`ifdef DIFERENCA_MASK_EN
        return x;
`else
        return 4'b0000;
`endif
    endfunction

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_window(input logic [7:0] l, input logic [1:0] m);
        start = 1'b1; len = l; mode = m;
        tick();
        start = 1'b0;
    endtask

    task automatic finish_window();
        in_valid = 1'b0; ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; len = '0; mode = '0;
        in_valid = 1'b0; a = '0; b = '0; ack = 1'b0;
        tick(); tick();
        checks++;
        if ({busy, done, diff_valid, diff, diff_mask, mismatch_cnt, first_idx, first_valid} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got busy=%b done=%b dv=%b diff=%b mask=%b cnt=%0d fi=%0d fv=%b, want all 0",
                     busy, done, diff_valid, diff, diff_mask, mismatch_cnt, first_idx, first_valid);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_mode0();
        begin_window(8'd2, 2'd0);
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL m0_busy: got %b want 1", busy); end
        in_valid = 1'b1; a = 4'b0100; b = 4'b0011;
        tick();
        checks++;
        if (diff_valid !== 1'b1 || diff !== 1'b1 || diff_mask !== exp_mask(4'b0111)) begin
            failures++;
            $display("FAIL m0_s0: got dv=%b diff=%b mask=%b want 1 1 %b", diff_valid, diff, diff_mask, exp_mask(4'b0111));
        end
        a = 4'b0110; b = 4'b0110;
        tick();
        checks++;
        if (diff !== 1'b0 || diff_mask !== 4'b0000 || done !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL m0_s1: got diff=%b mask=%b done=%b busy=%b want 0 0000 1 0", diff, diff_mask, done, busy);
        end
        checks++;
        if (mismatch_cnt !== 8'd1 || first_idx !== 8'd0 || first_valid !== 1'b1) begin
            failures++;
            $display("FAIL m0_summary: got cnt=%0d fi=%0d fv=%b want 1 0 1", mismatch_cnt, first_idx, first_valid);
        end
        finish_window();
        checks++;
        if (done !== 1'b0 || mismatch_cnt !== 8'd1) begin
            failures++;
            $display("FAIL m0_ack: got done=%b cnt=%0d want 0 1 (summary held in IDLE)", done, mismatch_cnt);
        end
    endtask

    task automatic test_modes_gt_lt();
        logic [3:0] va [3] = '{4'd5, 4'd3, 4'd7};
        logic [3:0] vb [3] = '{4'd3, 4'd5, 4'd7};
        logic       e1 [3] = '{1'b1, 1'b0, 1'b0};
        logic       e2 [3] = '{1'b0, 1'b1, 1'b0};
        for (int m = 1; m <= 2; m++) begin
            begin_window(8'd3, 2'(m));
            for (int i = 0; i < 3; i++) begin
                in_valid = 1'b1; a = va[i]; b = vb[i];
                tick();
                checks++;
                if (diff !== ((m == 1) ? e1[i] : e2[i]) || diff_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL mode%0d_s%0d: got diff=%b dv=%b want %b 1", m, i, diff, diff_valid,
                             (m == 1) ? e1[i] : e2[i]);
                end
            end
            checks++;
            if (done !== 1'b1 || mismatch_cnt !== 8'd1 || first_idx !== ((m == 1) ? 8'd0 : 8'd1) || first_valid !== 1'b1) begin
                failures++;
                $display("FAIL mode%0d_summary: got done=%b cnt=%0d fi=%0d fv=%b want 1 1 %0d 1",
                         m, done, mismatch_cnt, first_idx, first_valid, (m == 1) ? 0 : 1);
            end
            finish_window();
        end
    endtask

    task automatic test_stall();
        begin_window(8'd4, 2'd0);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; a = 4'(i); b = 4'(i);
            tick();
            checks++;
            if (diff_valid !== 1'b1 || done !== (i == 3)) begin
                failures++;
                $display("FAIL stall_s%0d: got dv=%b done=%b want 1 %b", i, diff_valid, done, (i == 3));
            end
            in_valid = 1'b0;
            tick();
            checks++;
            if (diff_valid !== 1'b0 || done !== (i == 3)) begin
                failures++;
                $display("FAIL stall_gap%0d: got dv=%b done=%b want 0 %b", i, diff_valid, done, (i == 3));
            end
        end
        in_valid = 1'b1; a = 4'hF; b = 4'h0;
        tick();
        checks++;
        if (diff_valid !== 1'b0 || diff !== 1'b0 || mismatch_cnt !== 8'd0 || first_valid !== 1'b0 || diff_mask !== 4'b0000) begin
            failures++;
            $display("FAIL stall_done_ignore: got dv=%b diff=%b cnt=%0d fv=%b mask=%b want 0 0 0 0 0000",
                     diff_valid, diff, mismatch_cnt, first_valid, diff_mask);
        end
        finish_window();
    endtask

    task automatic test_saturation();
        begin_window(8'd3, 2'd0);
        for (int i = 0; i < 3; i++) begin
            start = 1'b1; len = 8'd7; in_valid = 1'b1; a = 4'(i + 1); b = 4'd0;
            tick();
        end
        start = 1'b0; in_valid = 1'b0;
        checks++;
        if (done2 !== 1'b1 || mismatch_cnt2 !== 2'd3 || first_idx2 !== 2'd0 || first_valid2 !== 1'b1) begin
            failures++;
            $display("FAIL sat_narrow: got done=%b cnt=%0d fi=%0d fv=%b want 1 3 0 1", done2, mismatch_cnt2, first_idx2, first_valid2);
        end
        checks++;
        if (done !== 1'b1 || mismatch_cnt !== 8'd3) begin
            failures++;
            $display("FAIL sat_start_ignored: got done=%b cnt=%0d want 1 3", done, mismatch_cnt);
        end
        tick();
        checks++;
        if (mismatch_cnt2 !== 2'd3 || done2 !== 1'b1) begin
            failures++;
            $display("FAIL sat_hold: got cnt=%0d done=%b want 3 1", mismatch_cnt2, done2);
        end
        finish_window();
    endtask

    task automatic test_len0();
        begin_window(8'd0, 2'd0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || mismatch_cnt !== 8'd0 || first_valid !== 1'b0) begin
            failures++;
            $display("FAIL len0_done: got done=%b busy=%b cnt=%0d fv=%b want 1 0 0 0", done, busy, mismatch_cnt, first_valid);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (done !== 1'b1 || mismatch_cnt !== 8'd0 || first_idx !== 8'd0) begin
                failures++;
                $display("FAIL len0_hold%0d: got done=%b cnt=%0d fi=%0d want 1 0 0", i, done, mismatch_cnt, first_idx);
            end
        end
        ack = 1'b1; start = 1'b1; len = 8'd2;
        tick();
        ack = 1'b0; start = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL len0_ack: got done=%b busy=%b want 0 0", done, busy);
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL len0_start_ignored: got busy=%b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        begin_window(8'd4, 2'd0);
        in_valid = 1'b1; a = 4'd9; b = 4'd1; tick();
        a = 4'd2; b = 4'd3; tick();
        checks++;
        if (mismatch_cnt !== 8'd2) begin failures++; $display("FAIL rstmid_pre: got cnt=%0d want 2", mismatch_cnt); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; in_valid = 1'b0;
        checks++;
        if ({busy, done, diff_valid, diff, diff_mask, mismatch_cnt, first_idx, first_valid} !== '0) begin
            failures++;
            $display("FAIL rstmid_outputs: got busy=%b done=%b dv=%b diff=%b mask=%b cnt=%0d fi=%0d fv=%b want all 0",
                     busy, done, diff_valid, diff, diff_mask, mismatch_cnt, first_idx, first_valid);
        end
        begin_window(8'd2, 2'd0);
        in_valid = 1'b1; a = 4'd2; b = 4'd2; tick();
        a = 4'd1; b = 4'd0; tick();
        in_valid = 1'b0;
        checks++;
        if (done !== 1'b1 || mismatch_cnt !== 8'd1 || first_idx !== 8'd1 || first_valid !== 1'b1 || diff_mask !== exp_mask(4'b0001)) begin
            failures++;
            $display("FAIL rstmid_fresh: got done=%b cnt=%0d fi=%0d fv=%b mask=%b want 1 1 1 1 %b",
                     done, mismatch_cnt, first_idx, first_valid, diff_mask, exp_mask(4'b0001));
        end
        finish_window();
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_modes_gt_lt();
        test_stall();
        test_saturation();
        test_len0();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_diferenca.md
# seq_diferenca

Parametrised, clocked successor to the combinational 4-bit difference detector. It compares two WIDTH-bit operand streams over a programmed window of LEN samples. For each sample it reports a registered difference flag and a per-bit mask; at the end of the window it holds a mismatch count and the index of the first mismatch until the consumer acknowledges. It sits between a stimulus/producer pair and the ALU check logic, which reads one result summary per window.

## Interface
Parameters:
- WIDTH, 4, operand width in bits (≥1)
- CNT_W, 8, width of window length, index and count registers (≥2)

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  reset, synchronous, active-low
- start  input  1  begin a window; sampled only in IDLE
- len  input  CNT_W  window length in samples, latched on accepted start
- mode  input  2  compare mode, latched on accepted start: 0 = a≠b, 1 = a>b unsigned, 2 = a<b unsigned, 3 = treated as 0
- in_valid  input  1  a/b carry a sample this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- ack  input  1  consumer has taken the summary
- busy  output  1  high in RUN
- done  output  1  high in DONE; summary stable
- diff_valid  output  1  one-cycle pulse; diff/diff_mask updated
- diff  output  1  mode result for the last accepted sample
- diff_mask  output  WIDTH  a XOR b for the last accepted sample
- mismatch_cnt  output  CNT_W  samples with diff=1 in the window, saturating
- first_idx  output  CNT_W  index (0-based) of the first sample with diff=1
- first_valid  output  1  first_idx is meaningful

## Operation
FSM states: IDLE, RUN, DONE.
- IDLE: busy=0, done=0. On start=1:
  - latch len and mode, clear idx, mismatch_cnt, first_idx and first_valid.
  - If len≠0, go to RUN. If len=0, go directly to DONE with a zero summary.
- RUN: a sample is accepted when in_valid=1.
  - Per accepted sample: compute diff by mode; diff_mask = a^b; diff_valid pulses.
  - If diff=1: mismatch_cnt increments, holding at 2^CNT_W−1. If first_valid=0, set first_idx=idx and first_valid=1.
  - idx increments per accepted sample. The sample accepted with idx = len−1 moves the FSM to DONE.
  - start is ignored in RUN. in_valid=0 cycles are stalls: no state change, diff_valid=0.
- DONE: done=1. mismatch_cnt, first_idx, first_valid, diff and diff_mask are held.
  - ack=1 returns the FSM to IDLE. in_valid and start are ignored.
- IDLE after ack: the summary registers keep their values until the next accepted start.
- in_valid outside RUN produces no diff_valid and changes no output.

Reset (rst_n=0 at a rising edge, any state including mid-window) → IDLE. All outputs become 0: busy, done, diff_valid, diff, diff_mask, mismatch_cnt, first_idx, first_valid. Latched len, mode and idx are cleared.

## Timing
- All outputs are registered.
- diff_valid, diff and diff_mask appear one cycle after the edge that accepts the sample.
- busy rises the cycle after an accepted start.
- done rises the cycle after the last sample is accepted, with mismatch_cnt/first_idx final in that same cycle.
- len=0: done rises one cycle after start.
- done falls the cycle after ack is sampled high. start in that same cycle is ignored; a new start is accepted at the earliest on the following IDLE cycle.
- Maximum throughput: one sample per cycle. Minimum window period: len + 2 cycles (start, len samples, DONE with immediate ack).
- Simultaneous rst_n=0 with any input: reset wins.

## Configuration
- DIFERENCA_MASK_EN defined: the diff_mask register is implemented as described.
- Not defined: diff_mask is tied to all zeros, no mask flops are built, and all other behaviour is unchanged.

## Test plan
- WIDTH=4, mode 0, len=2; samples (0100,0011) then (0110,0110) → diff 1 then 0; diff_mask 0111 then 0000; done with mismatch_cnt=1, first_idx=0, first_valid=1.
- Mode 1, len=3; samples (5,3), (3,5), (7,7) → diff 1,0,0. Mode 2 with the same samples → diff 0,1,0; mismatch_cnt=1, first_idx=1.
- len=4 with in_valid gaps between samples and no mismatches → done only after the 4th accepted sample; mismatch_cnt=0, first_valid=0.
- CNT_W=2, len=3, all samples differ → mismatch_cnt=3 (saturation value held); start pulses during RUN are ignored.
- len=0 → done one cycle after start; hold ack low 5 cycles → done and the summary stay stable; ack → IDLE next cycle.
- rst_n low mid-window after 2 mismatches → next cycle all outputs 0, state IDLE; a fresh start then runs a full window correctly. Repeat without DIFERENCA_MASK_EN → diff_mask constantly 0.
